serial_frame_rx: RTL
====================

Name: serial_frame_rx

Overview:
Downstream consumer of the universal shift register's serial output (MSB/LSB shift-out chain). It reassembles framed serial bits into parallel words:
- frame = start bit, DATA_W data bits LSB-first, optional parity bit, stop bit
- checks parity and framing
- presents each word on a single-entry valid/ready output register to the next parallel stage.

Parameters:
DATA_W, 4, data bits per frame (2..16)
PARITY_EN, 1, 1 = parity bit present between data and stop
ODD_PARITY, 0, 0 = even parity, 1 = odd parity (ignored if PARITY_EN=0)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
bit_valid  input  1  bit_in is sampled only in cycles where this is 1
bit_in  input  1  serial data from shift register (idle line = 1)
out_data  output  DATA_W  received word
out_parity_err  output  1  parity mismatch flag for word in out_data
out_valid  output  1  out_data holds an unconsumed word
out_ready  input  1  downstream accepts word when out_valid & out_ready
frame_err  output  1  one-cycle pulse: stop bit sampled as 0
overrun  output  1  one-cycle pulse: completed frame dropped, output full
busy  output  1  1 whenever FSM is not IDLE

Behaviour:
- Reset, synchronous and active-high:
  - FSM to IDLE.
  - out_data=0, out_parity_err=0, out_valid=0, frame_err=0, overrun=0, busy=0.
  - Bit counter and shift register cleared.
  - Applies mid-frame: partial frame discarded, no flags raised.
- FSM states: IDLE, DATA, PARITY, STOP. Nothing advances in a cycle with bit_valid=0; all state, counters and partial data hold.
- IDLE: sampled bit 0 -> DATA, bit count = 0. Sampled bit 1 -> stay in IDLE.
- DATA:
  - Sampled bit is shifted in LSB-first (first data bit lands in out bit 0). Running parity XOR updated.
  - After DATA_W bits -> PARITY if PARITY_EN, else STOP.
  - Counter width = clog2(DATA_W+1). No wrap beyond DATA_W.
- PARITY: sampled bit is XORed into running parity -> STOP.
  - Error when total XOR != ODD_PARITY.
  - If PARITY_EN=0, parity error is always 0.
- STOP, on the sampled stop bit:
  - Stop bit = 1: frame complete -> IDLE.
  - Stop bit = 0: frame_err pulses the next cycle, word discarded -> IDLE. The 0 is not reinterpreted as a start bit.
- Output register:
  - Completed frame loads out_data/out_parity_err and sets out_valid on the clock edge after the stop bit is sampled (latency 1 cycle from stop sample).
  - out_valid stays high until handshake (out_valid & out_ready). Data is stable while out_valid=1 and !out_ready.
  - Frame completes while out_valid=1 and no handshake this cycle: new word dropped, overrun pulses one cycle, old word retained.
  - Frame completes in the same cycle as a handshake: old word is consumed, new word loaded, out_valid stays 1, no overrun.
  - Handshake with no completion: out_valid cleared next cycle.
- frame_err and overrun are registered single-cycle pulses and are never asserted together.
- Back-to-back frames: a start bit may be sampled the cycle immediately after the stop bit.

Decomposition:
- Shared package serial_frame_pkg holds:
  - FSM state typedef (IDLE, DATA, PARITY, STOP, 2-bit encoding)
  - IDLE_LEVEL=1'b1, START_LEVEL=1'b0, STOP_LEVEL=1'b1
- One natural sub-module: frame_out_reg, the single-entry valid/ready holding register with overrun detection, instantiated once. The FSM and deserializer stay in the top.

Test Plan:
- Good frame: DATA_W=4, even parity, bit_valid=1. bit_in = 0,0,1,1,0,0,1 -> out_valid=1 one cycle after the stop bit, out_data=4'b0110, out_parity_err=0, frame_err=0.
- Parity error: same frame with parity bit 1 (0,0,1,1,0,1,1) -> out_data=4'b0110, out_parity_err=1. Repeat with ODD_PARITY=1 and parity bit 1 -> out_parity_err=0.
- Framing error and gaps:
  - Stop bit 0 (0,1,0,1,0,0,0) -> frame_err pulses exactly one cycle, out_valid stays 0, FSM back in IDLE.
  - Same good frame with bit_valid=0 for 3 cycles between data bits 2 and 3 -> identical result, no errors.
- Overrun: out_ready=0, send 4'b0110 then 4'b1001 -> out_data stays 4'b0110, overrun pulses once after the second stop bit. Raise out_ready -> out_valid drops next cycle.
- Simultaneous handshake: out_ready asserted exactly in the cycle the second frame's stop bit is sampled -> out_data becomes 4'b1001, out_valid continuously 1, no overrun.
- Reset mid-frame: assert reset after 2 data bits -> next cycle busy=0, out_valid=0. A following good frame 4'b1111 (0,1,1,1,1,0,1) -> out_data=4'b1111.

Source files
------------

// File: rtl/serial_frame_rx_pkg.sv
// Shared types and line levels for the serial frame receiver.
package serial_frame_pkg;

  // Receiver FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage : serial_frame_pkg

// File: rtl/serial_frame_rx_if.sv
// Serial-in / parallel-out signal bundle for serial_frame_rx.
// master = upstream bit source + downstream consumer, slave = the receiver.
interface serial_frame_rx_if #(
  parameter int DATA_W = 4
);
  logic              bit_valid;
  logic              bit_in;
  logic [DATA_W-1:0] out_data;
  logic              out_parity_err;
  logic              out_valid;
  logic              out_ready;
  logic              frame_err;
  logic              overrun;
  logic              busy;

  modport master (
    output bit_valid, bit_in, out_ready,
    input  out_data, out_parity_err, out_valid, frame_err, overrun, busy
  );

  modport slave (
    input  bit_valid, bit_in, out_ready,
    output out_data, out_parity_err, out_valid, frame_err, overrun, busy
  );
endinterface : serial_frame_rx_if

// File: rtl/serial_frame_rx_frame_out_reg.sv
// Single-entry valid/ready holding register. A completed frame is loaded
// when the register is empty or being drained this cycle; otherwise the new
// word is dropped and a one-cycle overrun pulse is raised.
module frame_out_reg #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic              load_perr_i,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic              perr_o,
  output logic              valid_o,
  output logic              overrun_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              perr_q, perr_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;

  // Next-state: load on free slot or simultaneous drain, drop on full.
  always_comb begin
    data_d    = data_q;
    perr_d    = perr_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (load_i && (!valid_q || ready_i)) begin
      data_d  = load_data_i;
      perr_d  = load_perr_i;
      valid_d = 1'b1;
    end else if (load_i) begin
      overrun_d = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Output register state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q    <= '0;
      perr_q    <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      perr_q    <= perr_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_o    = data_q;
  assign perr_o    = perr_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule : frame_out_reg

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB-first, optional
// parity bit, stop bit. Deserializer and FSM live here; the completed word
// is handed to frame_out_reg for the valid/ready output stage.
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int DATA_W     = 4,
  parameter int PARITY_EN  = 1,
  parameter int ODD_PARITY = 0
) (
  input logic               clk,
  input logic               reset,
  serial_frame_rx_if.slave  bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              perr_q, perr_d;
  logic              frame_err_q, frame_err_d;
  logic              complete_s;

  // FSM next-state, deserializer and parity update; all hold without bit_valid.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    perr_d      = perr_q;
    frame_err_d = 1'b0;
    complete_s  = 1'b0;
    if (bus.bit_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.bit_in == START_LEVEL) begin
            state_d = ST_DATA;
            cnt_d   = '0;
            par_d   = 1'b0;
            perr_d  = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DATA: begin
          shift_d = {bus.bit_in, shift_q[DATA_W-1:1]};
          par_d   = par_q ^ bus.bit_in;
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            cnt_d   = CNT_W'(DATA_W);
            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_PARITY: begin
          par_d   = par_q ^ bus.bit_in;
          perr_d  = ((par_q ^ bus.bit_in) != 1'(ODD_PARITY));
          state_d = ST_STOP;
        end
        ST_STOP: begin
          // A 0 stop bit is not reused as a start bit.
          state_d = ST_IDLE;
          if (bus.bit_in == STOP_LEVEL) begin
            complete_s = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // FSM and deserializer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      perr_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      perr_q      <= perr_d;
      frame_err_q <= frame_err_d;
    end
  end

  frame_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk         (clk),
    .reset       (reset),
    .load_i      (complete_s),
    .load_data_i (shift_q),
    .load_perr_i (perr_q),
    .ready_i     (bus.out_ready),
    .data_o      (bus.out_data),
    .perr_o      (bus.out_parity_err),
    .valid_o     (bus.out_valid),
    .overrun_o   (bus.overrun)
  );

  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule : serial_frame_rx
